seg_scan_driver: RTL and testbench

//  Parametrised time-multiplexed 7-segment driver for DIGITS common-anode/cathode digits.

---
 rtl/seg_pkg.sv | 28 ++
 rtl/seg_hex_decoder.sv | 32 +++
 rtl/seg_scan_driver.sv | 171 +++++++++++++++++
 tb/tb_seg_scan_driver.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared glyph table and polarity helper for the multiplexed 7-segment driver.
// Glyphs are stored active-high as {g,f,e,d,c,b,a}; board polarity is applied last.
package seg_pkg;

  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_A   = 7'h77;
  localparam logic [6:0] SEG_B   = 7'h7C;
  localparam logic [6:0] SEG_C   = 7'h39;
  localparam logic [6:0] SEG_D   = 7'h5E;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_F   = 7'h71;
  localparam logic [6:0] SEG_OFF = 7'h00;

  // Convert an active-high {dp,g..a} pattern to the pin polarity of the board.
  function automatic logic [7:0] seg_pol(input logic [7:0] seg_on, input bit act_low);
    return act_low ? ~seg_on : seg_on;
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational 4-bit code to active-high 7-segment glyph (0-9 decimal, A-F hex).
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] glyph
);

  // Straight lookup of the glyph table.
  always_comb begin
    glyph = SEG_OFF;
    case (code)
      4'h0: glyph = SEG_0;
      4'h1: glyph = SEG_1;
      4'h2: glyph = SEG_2;
      4'h3: glyph = SEG_3;
      4'h4: glyph = SEG_4;
      4'h5: glyph = SEG_5;
      4'h6: glyph = SEG_6;
      4'h7: glyph = SEG_7;
      4'h8: glyph = SEG_8;
      4'h9: glyph = SEG_9;
      4'hA: glyph = SEG_A;
      4'hB: glyph = SEG_B;
      4'hC: glyph = SEG_C;
      4'hD: glyph = SEG_D;
      4'hE: glyph = SEG_E;
      default: glyph = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scanner: frame-synchronous double buffer, leading-zero
// suppression, per-digit blink and a dead-time window at the start of every digit slot.
// sel/seg are registered from the same counter state, so they always move together
// one clock after the counters.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS       = 6,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 500,
  parameter int BLINK_FRAMES = 100,
  parameter bit SEG_ACT_LOW  = 1'b1,
  parameter bit SEL_ACT_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   code_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blink_in,
  input  logic                  lz_en,
  output logic [DIGITS-1:0]     sel,
  output logic [7:0]            seg,
  output logic                  frame_done
);

  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_PRE   = SLOT_W'(SCAN_DIV - 2);
  localparam logic [SLOT_W-1:0] SLOT_BLANK = SLOT_W'(BLANK_CYC);
  localparam logic [DIG_W-1:0]  DIG_LAST   = DIG_W'(DIGITS - 1);
  localparam logic [FRM_W-1:0]  FRM_LAST   = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [DIGITS-1:0] SEL_IDLE   = SEL_ACT_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [7:0]        SEG_DARK   = SEG_ACT_LOW ? 8'hFF : 8'h00;

  logic [SLOT_W-1:0]   slot_cnt_reg;
  logic [DIG_W-1:0]    digit_reg;
  logic [FRM_W-1:0]    frm_cnt_reg;
  logic                blink_phase_reg;
  logic                enable_d_reg;
  logic [4*DIGITS-1:0] code_sh_reg, code_act_reg;
  logic [DIGITS-1:0]   dp_sh_reg, dp_act_reg;
  logic [DIGITS-1:0]   blink_sh_reg, blink_act_reg;
  logic [DIGITS-1:0]   sel_reg;
  logic [7:0]          seg_reg;
  logic                frame_done_reg;

  logic                slot_end, wrap, copy_act;
  logic [3:0]          dig_code;
  logic [6:0]          glyph;
  logic [DIGITS-1:0]   zero_from, sel_hi;
  logic                lz_blank;
  logic [7:0]          seg_on, seg_next;

  assign slot_end = (slot_cnt_reg == SLOT_LAST);
  assign wrap     = enable && slot_end && (digit_reg == DIG_LAST);
  // While dark (and on the first enabled cycle) the active set simply tracks the shadow,
  // so the first frame after enable shows the latest loaded data.
  assign copy_act = wrap || !enable || !enable_d_reg;

  // zero_from[i]: digit i and every more significant digit hold code 0.
  // sel_hi: one-hot of the digit currently being scanned.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign zero_from[gi] = ~|code_act_reg[4*DIGITS-1:4*gi];
    assign sel_hi[gi]    = (digit_reg == DIG_W'(gi));
  end

  assign dig_code = code_act_reg[{digit_reg, 2'b00} +: 4];
  assign lz_blank = lz_en && (digit_reg != '0) && zero_from[digit_reg];

  seg_hex_decoder u_dec (
    .code  (dig_code),
    .glyph (glyph)
  );

  // Slot counter and digit index; both held at 0 while disabled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_cnt_reg <= '0;
      digit_reg    <= '0;
      enable_d_reg <= 1'b0;
    end else begin
      enable_d_reg <= enable;
      if (!enable) begin
        slot_cnt_reg <= '0;
        digit_reg    <= '0;
      end else if (slot_end) begin
        slot_cnt_reg <= '0;
        digit_reg    <= (digit_reg == DIG_LAST) ? '0 : digit_reg + 1'b1;
      end else begin
        slot_cnt_reg <= slot_cnt_reg + 1'b1;
      end
    end
  end

  // Frame counter and blink phase; phase flips every BLINK_FRAMES frame wraps.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frm_cnt_reg     <= '0;
      blink_phase_reg <= 1'b0;
    end else if (!enable) begin
      frm_cnt_reg     <= '0;
      blink_phase_reg <= 1'b0;
    end else if (wrap) begin
      if (frm_cnt_reg == FRM_LAST) begin
        frm_cnt_reg     <= '0;
        blink_phase_reg <= ~blink_phase_reg;
      end else begin
        frm_cnt_reg <= frm_cnt_reg + 1'b1;
      end
    end
  end

  // Shadow captures every load; active only changes at a frame wrap (or while dark),
  // and a load landing on that same cycle bypasses the shadow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      code_sh_reg   <= '0;
      dp_sh_reg     <= '0;
      blink_sh_reg  <= '0;
      code_act_reg  <= '0;
      dp_act_reg    <= '0;
      blink_act_reg <= '0;
    end else begin
      if (load) begin
        code_sh_reg  <= code_in;
        dp_sh_reg    <= dp_in;
        blink_sh_reg <= blink_in;
      end
      if (copy_act) begin
        code_act_reg  <= load ? code_in  : code_sh_reg;
        dp_act_reg    <= load ? dp_in    : dp_sh_reg;
        blink_act_reg <= load ? blink_in : blink_sh_reg;
      end
    end
  end

  // Segment pattern for the current slot: LZ hides the glyph only, blink and dead time hide all.
  always_comb begin
    seg_on = {dp_act_reg[digit_reg], lz_blank ? SEG_OFF : glyph};
    if (blink_phase_reg && blink_act_reg[digit_reg]) seg_on = 8'h00;
    if (slot_cnt_reg < SLOT_BLANK) seg_on = 8'h00;
    seg_next = seg_pol(seg_on, SEG_ACT_LOW);
  end

  // Registered pin outputs; frame_done is high during the cycle whose edge wraps the frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel_reg        <= SEL_IDLE;
      seg_reg        <= SEG_DARK;
      frame_done_reg <= 1'b0;
    end else if (!enable) begin
      sel_reg        <= SEL_IDLE;
      seg_reg        <= SEG_DARK;
      frame_done_reg <= 1'b0;
    end else begin
      sel_reg        <= sel_hi ^ {DIGITS{SEL_ACT_LOW}};
      seg_reg        <= seg_next;
      frame_done_reg <= (slot_cnt_reg == SLOT_PRE) && (digit_reg == DIG_LAST);
    end
  end

  assign sel        = sel_reg;
  assign seg        = seg_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench: stimulus pushes the expected {sel,seg} of each digit slot of a frame,
// the monitor detects every new slot on the pins and checks its dead cycle and lit value.
module tb_seg_scan_driver;

  logic        clk, rstn, enable, load, lz_en;
  logic [23:0] code_in;
  logic [5:0]  dp_in, blink_in, sel;
  logic [7:0]  seg;
  logic        frame_done;

  typedef struct packed {
    logic [5:0] sel;
    logic [7:0] seg;
  } exp_t;

  exp_t q[$];
  exp_t exp_cur;
  logic pending;
  logic [5:0] prev_sel;
  int n_vec, n_err;

  seg_scan_driver #(
    .DIGITS(6), .SCAN_DIV(4), .BLANK_CYC(1), .BLINK_FRAMES(2),
    .SEG_ACT_LOW(1'b1), .SEL_ACT_LOW(1'b1)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .load(load), .code_in(code_in),
    .dp_in(dp_in), .blink_in(blink_in), .lz_en(lz_en), .sel(sel), .seg(seg),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end else begin
      $display("check %s: %h ok", name, act);
    end
  endtask

  // segs = {d5,d4,d3,d2,d1,d0}, active-low pin values.
  task automatic push_frame(input logic [47:0] segs);
    exp_t e;
    logic [5:0] s;
    for (int i = 0; i < 6; i++) begin
      s = ~(6'b000001 << i);
      e.sel = s;
      e.seg = segs[8*i +: 8];
      q.push_back(e);
    end
  endtask

  task automatic wait_fd();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL frame_done_timeout: got none, expected pulse within 200 clk");
    end
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !pending) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d slots still expected, expected 0", q.size());
      q.delete();
      pending = 1'b0;
    end
  endtask

  task automatic show_frame(input logic [23:0] c, input logic [5:0] d, input logic [5:0] b,
                            input logic lz, input logic [47:0] segs);
    load = 1'b1; code_in = c; dp_in = d; blink_in = b; lz_en = lz;
    @(negedge clk);
    load = 1'b0;
    wait_fd();
    push_frame(segs);
    wait_drain();
  endtask

  // Monitor: a change of sel to an active digit starts a slot; check dead cycle, then lit value.
  always @(negedge clk) begin
    if (pending) begin
      n_vec++;
      if (sel !== exp_cur.sel || seg !== exp_cur.seg) begin
        n_err++;
        $display("FAIL slot: got sel=%b seg=%h, expected sel=%b seg=%h", sel, seg, exp_cur.sel, exp_cur.seg);
      end else begin
        $display("slot sel=%b seg=%h ok", sel, seg);
      end
      pending = 1'b0;
    end else if (rstn && sel !== 6'h3F && sel !== prev_sel && q.size() > 0) begin
      exp_cur = q.pop_front();
      n_vec++;
      if (sel !== exp_cur.sel || seg !== 8'hFF) begin
        n_err++;
        $display("FAIL dead_cycle: got sel=%b seg=%h, expected sel=%b seg=ff", sel, seg, exp_cur.sel);
      end
      pending = 1'b1;
    end
    prev_sel = sel;
  end

  initial begin
    int cnt;
    n_vec = 0; n_err = 0; pending = 1'b0; prev_sel = 6'h3F;
    rstn = 1'b0; enable = 1'b0; load = 1'b0; lz_en = 1'b0;
    code_in = '0; dp_in = '0; blink_in = '0;
    repeat (2) @(negedge clk);
    check("reset_sel", {2'b00, sel}, 8'h3F);
    check("reset_seg", seg, 8'hFF);
    check("reset_frame_done", {7'd0, frame_done}, 8'h00);
    rstn = 1'b1;

    // Basic scan, loaded while dark.
    load = 1'b1; code_in = 24'h224640;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    check("dark_seg", seg, 8'hFF);
    push_frame(48'hA4_A4_99_82_99_C0);
    enable = 1'b1;
    @(negedge clk);
    check("enable_first_sel", {2'b00, sel}, 8'h3E);
    wait_fd();
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cnt++;
      if (frame_done) break;
    end
    check("frame_period", 8'(cnt), 8'd24);
    wait_drain();

    // Leading-zero suppression.
    show_frame(24'h000705, 6'h00, 6'h00, 1'b1, 48'hFF_FF_FF_F8_C0_92);
    show_frame(24'h000000, 6'h00, 6'h00, 1'b1, 48'hFF_FF_FF_FF_FF_C0);
    show_frame(24'h000000, 6'h00, 6'h00, 1'b0, 48'hC0_C0_C0_C0_C0_C0);

    // Mid-frame load must not tear the frame on display.
    load = 1'b1; code_in = 24'h111111;
    @(negedge clk);
    load = 1'b0;
    wait_fd();
    push_frame(48'hF9_F9_F9_F9_F9_F9);
    repeat (10) @(negedge clk);
    load = 1'b1; code_in = 24'h999999;
    @(negedge clk);
    load = 1'b0;
    wait_fd();
    push_frame(48'h90_90_90_90_90_90);
    wait_drain();

    // Disable, load while dark, blink over six frames.
    enable = 1'b0;
    @(negedge clk);
    check("disable_sel", {2'b00, sel}, 8'h3F);
    check("disable_seg", seg, 8'hFF);
    check("disable_frame_done", {7'd0, frame_done}, 8'h00);
    load = 1'b1; code_in = 24'h654321; blink_in = 6'b000011; lz_en = 1'b0;
    @(negedge clk);
    load = 1'b0;
    push_frame(48'h82_92_99_B0_A4_F9);
    push_frame(48'h82_92_99_B0_A4_F9);
    push_frame(48'h82_92_99_B0_FF_FF);
    push_frame(48'h82_92_99_B0_FF_FF);
    push_frame(48'h82_92_99_B0_A4_F9);
    push_frame(48'h82_92_99_B0_A4_F9);
    enable = 1'b1;
    wait_drain();

    // Load on the frame_done cycle reaches the very next frame; dp survives LZ.
    wait_fd();
    load = 1'b1; code_in = 24'h654321; dp_in = 6'b000100; blink_in = 6'h00;
    push_frame(48'h82_92_99_30_A4_F9);
    @(negedge clk);
    load = 1'b0;
    wait_drain();
    show_frame(24'h000000, 6'b001000, 6'h00, 1'b1, 48'hFF_FF_7F_FF_FF_C0);

    // Asynchronous reset in the middle of a slot.
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("async_reset_sel", {2'b00, sel}, 8'h3F);
    check("async_reset_seg", seg, 8'hFF);
    check("async_reset_frame_done", {7'd0, frame_done}, 8'h00);
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
